transmit_packet: RTL and testbench
==================================

Name: transmit_packet

Overview:
Downstream stage of the receive path. When the receive stage reports a stored packet, this block reads the packet back from the shared 32-bit packet RAM through an Avalon-MM read master. It serialises the bytes onto the MAC TX Avalon-ST interface (ff_tx_*), closing the SFP loopback. It runs in the same clk_original domain as the receive stage.

Parameters:
ADDR_W, 10, RAM word-address width
BASE_ADDR, 0, word address of the length header (payload starts at BASE_ADDR+1)
MAX_LEN, 4092, largest legal byte length; larger or zero lengths are rejected

Ports:
clk_original  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  data_saved from receive stage; rising edge starts a transmission
ram_addr  out  ADDR_W  Avalon-MM word address
ram_chipselect  out  1  Avalon-MM chipselect
ram_read  out  1  Avalon-MM read
ram_readdata  in  32  Avalon-MM read data, valid exactly 1 cycle after an accepted read
ram_waitrequest  in  1  Avalon-MM stall
ff_tx_data  out  8  TX byte
ff_tx_sop  out  1  first byte of frame
ff_tx_eop  out  1  last byte of frame
ff_tx_wren  out  1  byte valid
ff_tx_err  out  1  frame error, constant 0
ff_tx_crc_fwd  out  1  constant 0 (MAC appends CRC)
ff_tx_rdy  in  1  MAC TX FIFO ready
busy  out  1  high from start edge until return to IDLE
tx_done  out  1  1-cycle pulse after eop transfer
len_err  out  1  1-cycle pulse on rejected length

Behaviour:
- Reset: all outputs 0, ram_addr=0, state IDLE, start edge register cleared. Reset mid-packet truncates the frame with no eop, which is accepted behaviour.
- start is registered; edge = start & ~start_q. A level held high does not retrigger. Edges are ignored when not IDLE.
- RAM layout: word BASE_ADDR holds the byte length in bits [15:0]; the upper bits are ignored. Payload is little-endian: byte n is in word BASE_ADDR+1+n/4, bits [8*(n%4)+7 : 8*(n%4)].
- FSM transitions:
  - IDLE -> RD_LEN on edge.
  - RD_LEN: chipselect=read=1, addr=BASE_ADDR. Address and read are held while waitrequest=1. On waitrequest=0 -> LEN_WAIT.
  - LEN_WAIT: capture length from readdata. If len=0 or len>MAX_LEN -> pulse len_err -> IDLE. Otherwise remaining=len, addr=BASE_ADDR+1 -> RD_WORD.
  - RD_WORD: read handshake as in RD_LEN -> WORD_WAIT.
  - WORD_WAIT: load readdata into serializer. lanes = min(4, remaining) -> SEND.
  - SEND: ff_tx_wren=1 with current byte. A transfer occurs when wren & ff_tx_rdy. On transfer: advance lane and decrement remaining.
    - remaining reaches 0 -> DONE.
    - lanes exhausted with bytes still remaining -> addr+1 -> RD_WORD.
  - DONE: tx_done=1 for one cycle -> IDLE.
- ff_tx_sop=1 only with byte 0; ff_tx_eop=1 only with byte len-1. Both are 1 together when len=1.
- While ff_tx_rdy=0, data, sop, eop and wren are held stable; no byte is dropped or duplicated.
- ram_addr arithmetic is ADDR_W-bit. MAX_LEN guarantees no wrap for BASE_ADDR=0; wrap for other bases is modulo 2^ADDR_W.
- busy=1 in every state except IDLE.
- Latency from start edge to first wren, with waitrequest=0: 5 cycles.

Decomposition:
- Package tx_packet_pkg holds:
  - state enum (IDLE, RD_LEN, LEN_WAIT, RD_WORD, WORD_WAIT, SEND, DONE)
  - LEN_HDR_OFFSET=0, PAYLOAD_OFFSET=1
  - BYTES_PER_WORD=4, LEN_W=16
- Sub-module tx_byte_serializer: loads a 32-bit word plus lane count and emits bytes LSB-first under a valid/ready handshake. It flags "last lane" to the FSM.

Test Plan:
- Basic frame: mem[0]=6, mem[1]=0x44332211, mem[2]=0x00006655, rdy=1, start edge -> bytes 11 22 33 44 55 66 on 6 consecutive wren cycles. sop on 0x11, eop on 0x66. Reads at addr 0,1,2. tx_done 1 cycle after eop. busy low afterwards.
- Backpressure: same frame, ff_tx_rdy toggles 1,0,0,1 repeating -> each byte stable while rdy=0. Exactly 6 transfers, same sequence.
- Waitrequest: waitrequest=1 for 3 cycles on each read -> addr and read held constant throughout. Output identical to the basic frame.
- Length errors: mem[0]=0, then mem[0]=5000 -> len_err pulse each time. No wren, no payload reads, back to IDLE.
- Edge rules: start held high across a full frame -> exactly one frame. A second edge during SEND is ignored. A new edge after DONE -> second frame.
- Reset: assert rst after byte 3 of a 9-byte frame -> all outputs 0 immediately. A following start edge sends a full 9-byte frame with sop on byte 0.

Source files
------------

// File: rtl/tx_packet_pkg.sv
// Shared definitions for the packet transmit path.
//   tx_state_t      : transmit FSM state encoding
//   LEN_HDR_OFFSET  : word offset of the length header from BASE_ADDR
//   PAYLOAD_OFFSET  : word offset of the first payload word from BASE_ADDR
//   BYTES_PER_WORD  : byte lanes in one RAM word
//   LEN_W           : width of the length header field
//   lane_count()    : number of valid lanes for the next word given bytes remaining
package tx_packet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    LEN_WAIT,
    RD_WORD,
    WORD_WAIT,
    SEND,
    DONE
  } tx_state_t;

  localparam int unsigned LEN_HDR_OFFSET = 0;
  localparam int unsigned PAYLOAD_OFFSET = 1;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

  function automatic logic [2:0] lane_count(input logic [LEN_W-1:0] remaining);
    if (remaining >= LEN_W'(BYTES_PER_WORD)) begin
      return 3'(BYTES_PER_WORD);
    end
    return remaining[2:0];
  endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// Word-to-byte serializer for the transmit path.
// Holds one 32-bit RAM word and presents its bytes LSB-first.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture word_in and lanes_in, restart at lane 0
//   word_in    : 32-bit little-endian payload word
//   lanes_in   : number of valid bytes in word_in (1..4)
//   advance    : current byte accepted downstream; step to next lane
//   byte_out   : byte at the current lane
//   last_lane  : current lane is the final valid lane of the word
module tx_byte_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic [2:0]  lanes_in,
  input  logic        advance,
  output logic [7:0]  byte_out,
  output logic        last_lane
);

  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic [2:0]  lanes_q;
  logic [31:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      lane_q  <= '0;
      lanes_q <= '0;
    end else if (load) begin
      word_q  <= word_in;
      lane_q  <= '0;
      lanes_q <= lanes_in;
    end else if (advance && !last_lane) begin
      lane_q <= lane_q + 2'd1;
    end
  end

  always_comb begin
    shifted   = word_q >> {lane_q, 3'b000};
    byte_out  = shifted[7:0];
    last_lane = ({1'b0, lane_q} == (lanes_q - 3'd1));
  end

endmodule

// File: rtl/transmit_packet.sv
// Packet transmit stage: on a rising edge of start, reads a length-prefixed
// packet from the shared packet RAM over an Avalon-MM read master and
// streams it byte-by-byte onto the MAC TX Avalon-ST interface.
//   clk_original, rst       : clock, asynchronous active-high reset
//   start                   : packet-stored flag from receive stage (edge triggered)
//   ram_addr/chipselect/read: Avalon-MM read master request
//   ram_readdata            : read data, valid one cycle after an accepted read
//   ram_waitrequest         : slave stall
//   ff_tx_data/sop/eop/wren : TX byte stream, held while ff_tx_rdy is low
//   ff_tx_err, ff_tx_crc_fwd: tied low (MAC appends the CRC)
//   ff_tx_rdy               : MAC TX FIFO ready
//   busy                    : high whenever the FSM is not idle
//   tx_done                 : one-cycle pulse after the eop byte is accepted
//   len_err                 : one-cycle pulse when a header length is rejected
module transmit_packet
  import tx_packet_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_LEN   = 4092
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_chipselect,
  output logic              ram_read,
  input  logic [31:0]       ram_readdata,
  input  logic              ram_waitrequest,
  output logic [7:0]        ff_tx_data,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic              ff_tx_wren,
  output logic              ff_tx_err,
  output logic              ff_tx_crc_fwd,
  input  logic              ff_tx_rdy,
  output logic              busy,
  output logic              tx_done,
  output logic              len_err
);

  localparam logic [ADDR_W-1:0] LEN_ADDR = ADDR_W'(BASE_ADDR + int'(LEN_HDR_OFFSET));
  localparam logic [ADDR_W-1:0] PAY_ADDR = ADDR_W'(BASE_ADDR + int'(PAYLOAD_OFFSET));
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);

  tx_state_t        state, state_nxt;
  logic             start_q;
  logic             start_edge;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] len_word;
  logic             len_bad;
  logic             first_q;
  logic             xfer;
  logic             last_lane;
  logic             ser_load;
  logic [2:0]       ser_lanes;

  assign start_edge = start & ~start_q;
  assign len_word   = ram_readdata[LEN_W-1:0];
  assign len_bad    = (len_word == '0) || (len_word > MAX_LEN_V);
  assign xfer       = (state == SEND) && ff_tx_rdy;
  assign ser_load   = (state == WORD_WAIT);
  assign ser_lanes  = lane_count(remaining);

  assign ff_tx_err     = 1'b0;
  assign ff_tx_crc_fwd = 1'b0;

  tx_byte_serializer u_ser (
    .clk       (clk_original),
    .rst       (rst),
    .load      (ser_load),
    .word_in   (ram_readdata),
    .lanes_in  (ser_lanes),
    .advance   (xfer),
    .byte_out  (ff_tx_data),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ram_chipselect = 1'b0;
    ram_read       = 1'b0;
    ff_tx_wren     = 1'b0;
    ff_tx_sop      = 1'b0;
    ff_tx_eop      = 1'b0;
    busy           = 1'b1;
    tx_done        = 1'b0;
    len_err        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_edge) state_nxt = RD_LEN;
      end
      RD_LEN: begin
        ram_chipselect = 1'b1;
        ram_read       = 1'b1;
        if (!ram_waitrequest) state_nxt = LEN_WAIT;
      end
      LEN_WAIT: begin
        if (len_bad) begin
          len_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RD_WORD;
        end
      end
      RD_WORD: begin
        ram_chipselect = 1'b1;
        ram_read       = 1'b1;
        if (!ram_waitrequest) state_nxt = WORD_WAIT;
      end
      WORD_WAIT: state_nxt = SEND;
      SEND: begin
        ff_tx_wren = 1'b1;
        ff_tx_sop  = first_q;
        ff_tx_eop  = (remaining == LEN_W'(1));
        if (ff_tx_rdy) begin
          if (remaining == LEN_W'(1)) state_nxt = DONE;
          else if (last_lane)         state_nxt = RD_WORD;
        end
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
      first_q   <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) ram_addr <= LEN_ADDR;
        end
        LEN_WAIT: begin
          if (!len_bad) begin
            remaining <= len_word;
            ram_addr  <= PAY_ADDR;
            first_q   <= 1'b1;
          end
        end
        SEND: begin
          if (ff_tx_rdy) begin
            remaining <= remaining - LEN_W'(1);
            first_q   <= 1'b0;
            // Only step the address when another word is actually needed,
            // so a frame ending on a word boundary leaves addr on its last word.
            if (last_lane && (remaining != LEN_W'(1))) ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transmit_packet.sv
module tb_transmit_packet;

  logic        clk_original = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  ram_addr;
  logic        ram_chipselect;
  logic        ram_read;
  logic [31:0] ram_readdata;
  logic        ram_waitrequest;
  logic [7:0]  ff_tx_data;
  logic        ff_tx_sop;
  logic        ff_tx_eop;
  logic        ff_tx_wren;
  logic        ff_tx_err;
  logic        ff_tx_crc_fwd;
  logic        ff_tx_rdy;
  logic        busy;
  logic        tx_done;
  logic        len_err;

  always #5 clk_original = ~clk_original;

  transmit_packet #(.ADDR_W(10), .BASE_ADDR(0), .MAX_LEN(4092)) dut (
    .clk_original    (clk_original),
    .rst             (rst),
    .start           (start),
    .ram_addr        (ram_addr),
    .ram_chipselect  (ram_chipselect),
    .ram_read        (ram_read),
    .ram_readdata    (ram_readdata),
    .ram_waitrequest (ram_waitrequest),
    .ff_tx_data      (ff_tx_data),
    .ff_tx_sop       (ff_tx_sop),
    .ff_tx_eop       (ff_tx_eop),
    .ff_tx_wren      (ff_tx_wren),
    .ff_tx_err       (ff_tx_err),
    .ff_tx_crc_fwd   (ff_tx_crc_fwd),
    .ff_tx_rdy       (ff_tx_rdy),
    .busy            (busy),
    .tx_done         (tx_done),
    .len_err         (len_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [0:1023];
  int stall_cfg = 0;
  int stall_cnt;

  assign ram_waitrequest = ram_chipselect && ram_read && (stall_cnt < stall_cfg);

  always @(posedge clk_original or posedge rst) begin
    if (rst) begin
      stall_cnt    <= 0;
      ram_readdata <= '0;
    end else if (ram_chipselect && ram_read) begin
      if (ram_waitrequest) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt    <= 0;
        ram_readdata <= mem[ram_addr];
      end
    end
  end

  // ---------------- ready generator ----------------
  int rdy_mode = 0;
  int rdy_phase = 0;
  initial begin
    ff_tx_rdy = 1'b1;
    forever begin
      @(posedge clk_original);
      #1;
      if (rdy_mode == 1) begin
        ff_tx_rdy = (rdy_phase == 0) || (rdy_phase == 3);
        rdy_phase = (rdy_phase + 1) % 4;
      end else begin
        ff_tx_rdy = 1'b1;
        rdy_phase = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_byte_q [$];   // {data, sop, eop}
  logic [9:0] exp_addr_q [$];
  int xfer_cnt = 0, done_cnt = 0, lenerr_cnt = 0;

  task automatic push_b(input logic [7:0] d, input logic s, input logic e);
    exp_byte_q.push_back({d, s, e});
  endtask

  task automatic push_a(input logic [9:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_frame6();
    push_b(8'h11, 1'b1, 1'b0);
    push_b(8'h22, 1'b0, 1'b0);
    push_b(8'h33, 1'b0, 1'b0);
    push_b(8'h44, 1'b0, 1'b0);
    push_b(8'h55, 1'b0, 1'b0);
    push_b(8'h66, 1'b0, 1'b1);
    push_a(10'd0); push_a(10'd1); push_a(10'd2);
  endtask

  task automatic push_frame9();
    for (int i = 0; i < 9; i++) push_b(8'hA1 + 8'(i), i == 0, i == 8);
    for (int i = 0; i < 4; i++) push_a(10'(i));
  endtask

  // ---------------- monitor ----------------
  logic       hold_prev, rd_hold_prev, eop_prev;
  logic [9:0] prev_out, prev_addr, got;

  always @(negedge clk_original) begin
    if (rst) begin
      hold_prev    = 1'b0;
      rd_hold_prev = 1'b0;
      eop_prev     = 1'b0;
    end else begin
      if (eop_prev) check("tx_done_after_eop", {31'b0, tx_done}, 32'd1);
      else if (tx_done) begin
        checks++; errors++;
        $display("FAIL tx_done_spurious: got 1 expected 0");
      end
      if (tx_done) done_cnt++;
      if (len_err) lenerr_cnt++;

      if (hold_prev) begin
        check("hold_wren", {31'b0, ff_tx_wren}, 32'd1);
        check("hold_byte", {22'b0, ff_tx_data, ff_tx_sop, ff_tx_eop}, {22'b0, prev_out});
      end
      if (ff_tx_wren && ff_tx_rdy) begin
        xfer_cnt++;
        if (exp_byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", ff_tx_data);
        end else begin
          got = exp_byte_q.pop_front();
          check("tx_byte", {22'b0, ff_tx_data, ff_tx_sop, ff_tx_eop}, {22'b0, got});
        end
      end
      eop_prev  = ff_tx_wren && ff_tx_rdy && ff_tx_eop;
      hold_prev = ff_tx_wren && !ff_tx_rdy;
      prev_out  = {ff_tx_data, ff_tx_sop, ff_tx_eop};

      if (rd_hold_prev) begin
        check("rd_hold_read", {31'b0, ram_read & ram_chipselect}, 32'd1);
        check("rd_hold_addr", {22'b0, ram_addr}, {22'b0, prev_addr});
      end
      if (ram_chipselect && ram_read && !ram_waitrequest) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr 0x%0h expected none", ram_addr);
        end else begin
          got = exp_addr_q.pop_front();
          check("rd_addr", {22'b0, ram_addr}, {22'b0, got});
        end
      end
      rd_hold_prev = ram_chipselect && ram_read && ram_waitrequest;
      prev_addr    = ram_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk_original); #1 start = 1'b1;
    @(posedge clk_original); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_original); #2;
      if (!busy && exp_byte_q.size() == 0 && exp_addr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy=%0d bytes_left=%0d expected idle", name, busy, exp_byte_q.size());
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_wren",    {31'b0, ff_tx_wren}, 32'd0);
    check("rst_sop",     {31'b0, ff_tx_sop}, 32'd0);
    check("rst_eop",     {31'b0, ff_tx_eop}, 32'd0);
    check("rst_data",    {24'b0, ff_tx_data}, 32'd0);
    check("rst_cs_rd",   {30'b0, ram_chipselect, ram_read}, 32'd0);
    check("rst_addr",    {22'b0, ram_addr}, 32'd0);
    check("rst_busy",    {31'b0, busy}, 32'd0);
    check("rst_pulses",  {30'b0, tx_done, len_err}, 32'd0);
    check("rst_err_crc", {30'b0, ff_tx_err, ff_tx_crc_fwd}, 32'd0);
  endtask

  int base_done, base_xfer, base_lerr, lat;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'd6; mem[1] = 32'h44332211; mem[2] = 32'h00006655;
    repeat (2) @(posedge clk_original);
    #1 check_outputs_zero();
    @(negedge clk_original) rst = 1'b0;
    repeat (2) @(posedge clk_original);

    // basic frame + latency
    push_frame6();
    base_done = done_cnt;
    @(posedge clk_original); #1 start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_original); #1;
      if (ff_tx_wren) begin lat = k; break; end
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd5);
    wait_done("basic");
    check("basic_frames", 32'(done_cnt - base_done), 32'd1);
    check("basic_busy", {31'b0, busy}, 32'd0);

    // backpressure
    rdy_mode = 1;
    push_frame6();
    base_xfer = xfer_cnt;
    pulse_start();
    wait_done("bp");
    check("bp_xfers", 32'(xfer_cnt - base_xfer), 32'd6);
    rdy_mode = 0;

    // waitrequest stalls
    stall_cfg = 3;
    push_frame6();
    base_done = done_cnt;
    pulse_start();
    wait_done("wait");
    check("wait_frames", 32'(done_cnt - base_done), 32'd1);
    stall_cfg = 0;

    // length errors
    foreach (mem[i]) if (i == 0) mem[i] = 32'd0;
    for (int t = 0; t < 3; t++) begin
      mem[0] = (t == 0) ? 32'd0 : (t == 1) ? 32'd5000 : 32'hFFFF_1001; // 4097 in low half
      push_a(10'd0);
      base_lerr = lenerr_cnt; base_xfer = xfer_cnt;
      pulse_start();
      wait_done("lenerr");
      check("lenerr_pulse", 32'(lenerr_cnt - base_lerr), 32'd1);
      check("lenerr_no_bytes", 32'(xfer_cnt - base_xfer), 32'd0);
    end

    // single-byte frame: sop and eop together
    mem[0] = 32'h0005_0001; mem[1] = 32'h000000AB;
    push_b(8'hAB, 1'b1, 1'b1); push_a(10'd0); push_a(10'd1);
    pulse_start();
    wait_done("len1");

    // exactly one word: no extra read
    mem[0] = 32'd4; mem[1] = 32'hDDCCBBAA;
    push_b(8'hAA, 1'b1, 1'b0); push_b(8'hBB, 1'b0, 1'b0);
    push_b(8'hCC, 1'b0, 1'b0); push_b(8'hDD, 1'b0, 1'b1);
    push_a(10'd0); push_a(10'd1);
    pulse_start();
    wait_done("len4");

    // start held high across a full frame
    mem[0] = 32'd6; mem[1] = 32'h44332211; mem[2] = 32'h00006655;
    push_frame6();
    base_done = done_cnt;
    @(posedge clk_original); #1 start = 1'b1;
    @(posedge clk_original);
    wait_done("held");
    repeat (10) @(posedge clk_original);
    #1 check("held_frames", 32'(done_cnt - base_done), 32'd1);
    check("held_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;

    // second edge during SEND ignored, edge after DONE starts a new frame
    push_frame6();
    base_done = done_cnt;
    pulse_start();
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_original); #1;
      if (ff_tx_wren) begin lat = 1; break; end
    end
    check("reach_send", 32'(lat), 32'd1);
    start = 1'b1;
    @(posedge clk_original); #1 start = 1'b0;
    wait_done("edge_in_send");
    repeat (5) @(posedge clk_original);
    check("ignored_edge_frames", 32'(done_cnt - base_done), 32'd1);
    push_frame6();
    pulse_start();
    wait_done("edge_after_done");
    check("new_edge_frames", 32'(done_cnt - base_done), 32'd2);

    // reset mid-frame, then full 9-byte frame
    mem[0] = 32'd9; mem[1] = 32'hA4A3A2A1; mem[2] = 32'hA8A7A6A5; mem[3] = 32'h000000A9;
    push_frame9();
    base_xfer = xfer_cnt;
    pulse_start();
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_original); #2;
      if (xfer_cnt - base_xfer >= 3) begin lat = 1; break; end
    end
    check("reach_byte3", 32'(lat), 32'd1);
    rst = 1'b1;
    #1 check_outputs_zero();
    exp_byte_q.delete();
    exp_addr_q.delete();
    @(posedge clk_original);
    @(negedge clk_original) rst = 1'b0;
    push_frame9();
    base_xfer = xfer_cnt; base_done = done_cnt;
    pulse_start();
    wait_done("after_rst");
    check("after_rst_xfers", 32'(xfer_cnt - base_xfer), 32'd9);
    check("after_rst_frames", 32'(done_cnt - base_done), 32'd1);

    repeat (3) @(posedge clk_original);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
